ofm_readout_engine: RTL and testbench
=====================================

Name: ofm_readout_engine

Overview:
- Drains the final-layer OFM region of the OFM dual-port RAM after the accelerator asserts done_CNN.
- Streams one DATA_WIDTH word per beat over a valid/ready interface to the host/DMA side.
- Sits directly downstream of yolov3_tiny. It replaces the bench-side direct memory peek with synthesizable readout.
- Fully sustains one word per cycle under continuous ready, and holds data stable under backpressure.

Parameters:
- DATA_WIDTH, 64, OFM word width.
- OFM_RAM_SIZE, 2378675, OFM RAM depth in words; ADDR_WIDTH = $clog2(OFM_RAM_SIZE) is derived locally.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 and not user-changeable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; the only reset.
- start  in  1  single-cycle request, normally wired to done_CNN.
- cfg_base_addr  in  ADDR_WIDTH  first OFM word address (layer-6 pooled output: 253776); latched on accepted start.
- cfg_num_words  in  ADDR_WIDTH  words to stream (3x3x16 = 144); latched on accepted start.
- ram_rd_en  out  1  OFM RAM port-A read enable.
- ram_addr  out  ADDR_WIDTH  OFM RAM port-A address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after ram_rd_en.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  high with the final word.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  one-cycle pulse on a rejected range; coincides with done.

Behaviour:
- Reset: all outputs are 0; state = IDLE; FIFO, counters and in-flight flag are cleared. Reset mid-stream aborts immediately. No done pulse is produced, and no RAM read is issued until the next start.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 latches cfg_*, sets busy, and moves to the next state:
  - cfg_num_words==0: go to FIN, no reads.
  - cfg_base_addr+cfg_num_words > OFM_RAM_SIZE (computed ADDR_WIDTH+1 wide): go to FIN with err flagged, no reads.
  - Otherwise: go to RUN.
- start while busy is ignored, and cfg changes mid-run have no effect.
- RUN issue rule: pop = m_valid & m_ready. credit = FIFO_DEPTH - fifo_count - inflight + pop.
  - ram_rd_en = (issued < num_words) & (credit > 0).
  - ram_addr = base + issued.
  - issued increments on every issue.
- inflight register = ram_rd_en of the previous cycle. When set, ram_rd_data is pushed into the FIFO at the next edge.
- When issued == num_words after an issue, go to DRAIN.
- DRAIN: wait until inflight==0 and the FIFO is empty (last pop done), then go to FIN.
- FIN: lasts one cycle. done=1, plus err=1 if the range was rejected. Clears busy at exit and returns to IDLE.
- Output ordering and content:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = head is word index num_words-1 (tag stored per entry).
- Backpressure: while m_valid & !m_ready, m_data and m_last stay stable. No RAM read is issued that would overflow the FIFO.
- Simultaneous push and pop in one cycle is legal, and fifo_count is unchanged.
- Latency: start sampled at edge k; first ram_rd_en in cycle k+1; first m_valid after edge k+2.
- Throughput: with m_ready held high, N words finish with done at edge k+N+3.
- Data is passed through unmodified. No sign or width conversion; the consumer interprets it as signed.
- The addresses issued are exactly base .. base+num-1, each once, in increasing order. No wrap-around is possible because out-of-range requests are rejected.

Test Plan:
- Full drain: preload the RAM with addr-tagged words, start with base=253776, num=144, m_ready=1. Expect 144 beats with m_data = mem[253776+i] in order, m_last only on beat 143, and done at start+147 cycles, err=0.
- Backpressure: same config with m_ready toggling pseudo-randomly, including 10-cycle stalls. Expect identical ordered data, no drops or duplicates, m_data stable during stalls, and never more than 2 reads outstanding+buffered.
- Zero length: num=0. Expect no ram_rd_en and no m_valid; done=1 one cycle after start, err=0.
- Range error: base=2378600, num=100. Expect no ram_rd_en; done=1 and err=1 together, then back to IDLE.
- Start while busy: second start with different cfg mid-stream. Expect it ignored and the original 144 words streamed.
- Reset mid-stream: assert rst after 50 beats. Expect all outputs 0 immediately and no done. A new start then streams correctly from word 0.

Source files
------------

// File: rtl/ofm_readout_engine.sv
// ofm_readout_engine
// Drains a contiguous word range of the OFM dual-port RAM after the CNN
// signals completion, and streams it one word per beat over valid/ready.
// A 2-entry output buffer with credit-based read issue sustains one word
// per cycle under continuous ready and never overflows under backpressure.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             single-cycle request (typically done_CNN)
//   cfg_base_addr     first OFM word address, latched on accepted start
//   cfg_num_words     number of words to stream, latched on accepted start
//   ram_rd_en         OFM RAM port-A read enable
//   ram_addr          OFM RAM port-A address
//   ram_rd_data       RAM read data, valid one cycle after ram_rd_en
//   m_valid/m_ready   output handshake
//   m_data, m_last    output word and final-word marker
//   busy              high from accepted start until completion
//   done              one-cycle completion pulse
//   err               one-cycle pulse with done when the range was rejected
module ofm_readout_engine #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned OFM_RAM_SIZE = 2378675,
  localparam int unsigned ADDR_WIDTH  = $clog2(OFM_RAM_SIZE),
  localparam int unsigned FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_num_words,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CRD_W = 3;
  localparam logic [ADDR_WIDTH:0] RAM_SIZE_W = (ADDR_WIDTH+1)'(OFM_RAM_SIZE);

  logic [1:0]            state_q, state_d;
  logic                  rej_q, rej_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  done_q, err_q, busy_q;

  logic                  accept_c;
  logic                  pop_c;
  logic                  issue_c;
  logic                  issue_last_c;
  logic [CRD_W-1:0]      credit_c;
  logic [ADDR_WIDTH:0]   end_addr_c;
  logic                  range_bad_c;

  // Handshake, credit and issue decisions for the current cycle
  always_comb begin
    accept_c     = (state_q == S_IDLE) && start;
    pop_c        = (count_q != '0) && m_ready;
    // Slots left once buffered words and the in-flight read land; a pop this
    // cycle frees one, which is what lets the stream run back-to-back.
    credit_c     = CRD_W'(FIFO_DEPTH) - CRD_W'(count_q) - CRD_W'(inflight_q) + CRD_W'(pop_c);
    issue_c      = (state_q == S_RUN) && (issued_q < num_q) && (credit_c != '0);
    issue_last_c = (issued_q == num_q - ADDR_WIDTH'(1));
    end_addr_c   = {1'b0, cfg_base_addr} + {1'b0, cfg_num_words};
    range_bad_c  = end_addr_c > RAM_SIZE_W;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rej_d = 1'b0;
          if (cfg_num_words == '0) begin
            state_d = S_FIN;
          end else if (range_bad_c) begin
            state_d = S_FIN;
            rej_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue_c && issue_last_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight_q && (count_q == '0)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and status outputs; done/err are registered copies of FIN entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rej_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rej_q   <= rej_d;
      done_q  <= (state_d == S_FIN);
      err_q   <= (state_d == S_FIN) && rej_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Address generation and read tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      issued_q        <= '0;
      num_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q   <= cfg_base_addr;
        num_q    <= cfg_num_words;
        issued_q <= '0;
      end else if (issue_c) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        issued_q <= issued_q + ADDR_WIDTH'(1);
      end
      inflight_q      <= issue_c;
      inflight_last_q <= issue_c && issue_last_c;
    end
  end

  // Output buffer: push lands the in-flight read, pop on accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= ram_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
    end
  end

  assign ram_rd_en = issue_c;
  assign ram_addr  = addr_q;
  assign m_valid   = (count_q != '0);
  assign m_data    = fifo_data_q[rd_ptr_q];
  assign m_last    = fifo_last_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ofm_readout_engine.sv
// Testbench for ofm_readout_engine: behavioural RAM, randomized ready,
// expected stream derived from base/num and the RAM content function.
module tb_ofm_readout_engine;

  localparam int unsigned DW   = 64;
  localparam int unsigned SIZE = 2378675;
  localparam int unsigned AW   = $clog2(SIZE);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_num_words;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ofm_readout_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Address-tagged RAM content
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B9;
    return {h, 10'h2B5, a};
  endfunction

  // Synchronous-read RAM model: data one cycle after the read enable
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem_word(ram_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode 0: ready always high; mode 1: random ready with occasional 10-cycle stalls
  task automatic run_txn(input logic [AW-1:0] base, input logic [AW-1:0] num,
                         input int mode, input int abort_after, input bit busy_start);
    int  k, nrd, nbeats, stall, exp_n;
    bit  exp_err, seen_done, prev_stall, seen_valid;
    logic [DW-1:0] prev_data;
    logic prev_last;
    exp_err    = (num != 0) && (longint'(base) + longint'(num) > longint'(SIZE));
    exp_n      = (num == 0 || exp_err) ? 0 : int'(num);
    nrd        = 0;
    nbeats     = 0;
    stall      = 0;
    seen_done  = 0;
    prev_stall = 0;
    seen_valid = 0;
    prev_data  = '0;
    prev_last  = 1'b0;

    @(negedge clk);
    cfg_base_addr = base;
    cfg_num_words = num;
    start   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    k = cyc;
    cfg_base_addr = AW'($urandom);
    cfg_num_words = AW'($urandom);
    for (int t = 0; t < 4000 && !seen_done; t++) begin
      if (t > 0) @(negedge clk);
      if (mode == 0) begin
        m_ready = 1'b1;
      end else if (stall > 0) begin
        m_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 19) == 0) begin
        m_ready = 1'b0;
        stall   = 9;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
      if (busy_start && t == 20) begin
        start = 1'b1;
        cfg_base_addr = AW'(0);
        cfg_num_words = AW'(5);
      end else begin
        start = 1'b0;
      end
      #1;
      if (t == 0) check("busy_after_start", 64'(busy), 64'(1));
      if (ram_rd_en) begin
        check("rd_in_range", 64'(nrd < exp_n), 64'(1));
        check("rd_addr", 64'(ram_addr), 64'(base) + 64'(nrd));
        if (nrd == 0) check("rd_latency", 64'(cyc), 64'(k));
        nrd++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", m_data, prev_data);
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        check("valid_latency", 64'(cyc), 64'(k + 2));
      end
      if (m_valid && m_ready) begin
        check("beat_data", m_data, mem_word(AW'(64'(base) + 64'(nbeats))));
        check("beat_last", 64'(m_last), 64'(nbeats == exp_n - 1));
        nbeats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      check("outstanding_le2", 64'((nrd - nbeats) <= 2), 64'(1));
      if (done) begin
        seen_done = 1;
        check("err_at_done", 64'(err), 64'(exp_err));
        check("beats_total", 64'(nbeats), 64'(exp_n));
        check("reads_total", 64'(nrd), 64'(exp_n));
        if (mode == 0)
          check("done_cycle", 64'(cyc), (exp_n == 0) ? 64'(k) : 64'(k + exp_n + 3));
      end else if (err) begin
        check("err_without_done", 64'(err), 64'(0));
      end
      if (abort_after > 0 && nbeats >= abort_after) begin
        rst = 1'b1;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", m_data, 64'(0));
        check("rst_rd_en", 64'(ram_rd_en), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          check("rst_no_done", 64'(done), 64'(0));
        end
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          #1;
          check("post_rst_idle", 64'({done, busy, ram_rd_en, m_valid}), 64'(0));
        end
        return;
      end
    end
    if (!seen_done) check("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
    #1;
    check("idle_after_done", 64'({done, err, busy, m_valid, ram_rd_en}), 64'(0));
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    m_ready       = 1'b0;
    cfg_base_addr = '0;
    cfg_num_words = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          64'({ram_rd_en, m_valid, m_last, busy, done, err}), 64'(0));
    check("reset_m_data", m_data, 64'(0));
    check("reset_ram_addr", 64'(ram_addr), 64'(0));
    rst = 1'b0;

    run_txn(AW'(253776), AW'(144), 0, 0, 1'b0);     // full drain
    run_txn(AW'(253776), AW'(144), 1, 0, 1'b0);     // backpressure
    run_txn(AW'(253776), AW'(0), 0, 0, 1'b0);       // zero length
    run_txn(AW'(2378600), AW'(100), 0, 0, 1'b0);    // range error
    run_txn(AW'(253776), AW'(144), 0, 0, 1'b1);     // start while busy
    run_txn(AW'(253776), AW'(144), 1, 50, 1'b0);    // reset mid-stream
    run_txn(AW'(253776), AW'(144), 0, 0, 1'b0);     // clean restart
    run_txn(AW'(SIZE - 3), AW'(3), 1, 0, 1'b0);     // ends exactly at RAM top
    run_txn(AW'(SIZE - 3), AW'(4), 0, 0, 1'b0);     // one word past the top
    run_txn(AW'(0), AW'(1), 0, 0, 1'b0);            // single word
    for (int i = 0; i < 4; i++)
      run_txn(AW'($urandom_range(0, SIZE - 64)), AW'($urandom_range(1, 40)), 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
